// File: rtl/usb_rx_sequencer_pkg.sv
// Shared types and constants for the USB full-speed receive sequencer.
package usb_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        DATA,
        EOP_WAIT,
        ERR
    } rx_state_e;

    localparam logic [7:0] SYNC_BYTE       = 8'h80;
    localparam int         DEF_STUFF_LIMIT = 6;
    localparam int         DEF_MAX_BYTES   = 64;

    // A PID byte carries its own check nibble: upper nibble is the complement of the lower.
    function automatic logic pid_valid(input logic [7:0] pid);
        return pid[7:4] == ~pid[3:0];
    endfunction

endpackage

// File: rtl/usb_rx_sequencer_if.sv
// Bit-stream inputs from the NRZI decoder / bit timer and status/FIFO outputs of the RX sequencer.
interface usb_rx_sequencer_if;

    logic       d_edge;
    logic       shift_enable;
    logic       d_orig;
    logic       eop;
    logic       rcving;
    logic       w_enable;
    logic [7:0] rx_data;
    logic       r_error;
    logic [6:0] byte_count;

    modport master (
        output d_edge, shift_enable, d_orig, eop,
        input  rcving, w_enable, rx_data, r_error, byte_count
    );

    modport slave (
        input  d_edge, shift_enable, d_orig, eop,
        output rcving, w_enable, rx_data, r_error, byte_count
    );

endinterface

// File: rtl/usb_rx_sequencer_shifter.sv
// LSB-first byte assembler: bits enter at bit 7 and shift down, so the first bit ends up in bit 0.
module rx_byte_shifter (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       clear,
    input  logic       shift,
    input  logic       bit_in,
    output logic [7:0] byte_val,
    output logic [2:0] bit_cnt,
    output logic       byte_done
);

    logic [7:0] sr_q, sr_d;
    logic [2:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (clear) begin
            sr_d  = '0;
            cnt_d = '0;
        end else if (shift) begin
            sr_d  = {bit_in, sr_q[7:1]};
            cnt_d = cnt_q + 3'd1;
        end
    end

    // The completed byte is presented combinationally so the FSM can judge it on the same bit event.
    assign byte_val  = {bit_in, sr_q[7:1]};
    assign bit_cnt   = cnt_q;
    assign byte_done = shift && !clear && (cnt_q == 3'd7);

endmodule

// File: rtl/usb_rx_sequencer.sv
// USB FS receive sequencer: SYNC check, bit unstuffing, byte assembly, EOP framing.
// Optional build macro RX_PID_CHECK_EN validates the first data byte as a PID.
//
// state    | meaning
// IDLE     | bus idle, waiting for d_edge to start a packet
// SYNC     | collecting the 8 SYNC bits, must equal 8'h80
// DATA     | assembling data bytes and writing them to the FIFO
// EOP_WAIT | end of packet seen, waiting for the bus to leave SE0
// ERR      | packet error, waiting for SE0 before resynchronising
module usb_rx_sequencer
    import usb_rx_pkg::*;
#(
    parameter int MAX_BYTES   = DEF_MAX_BYTES,
    parameter int STUFF_LIMIT = DEF_STUFF_LIMIT
) (
    input  logic                clk,
    input  logic                n_rst,
    usb_rx_sequencer_if.slave   bus
);

    localparam int ONES_W = $clog2(STUFF_LIMIT + 1);

    rx_state_e           state_q, state_d;
    logic                rcving_q, rcving_d;
    logic                w_enable_q, w_enable_d;
    logic                r_error_q, r_error_d;
    logic [7:0]          rx_data_q, rx_data_d;
    logic [6:0]          byte_count_q, byte_count_d;
    logic [ONES_W-1:0]   ones_q, ones_d;

    logic                bit_ev;
    logic                start;
    logic                in_pkt;
    logic                stuff_slot;
    logic                keep_bit;
    logic                stuff_err;
    logic                byte_done;
    logic [7:0]          byte_val;
    logic [2:0]          bit_cnt;
    logic                sync_ok;
    logic                overflow;
    logic                pid_bad;
    logic                data_byte;
    logic                write_ok;

    assign bit_ev     = bus.shift_enable;
    assign start      = (state_q == IDLE) && bus.d_edge;
    assign in_pkt     = (state_q == SYNC) || (state_q == DATA);
    assign stuff_slot = (ones_q == ONES_W'(STUFF_LIMIT));

    // eop outranks both stuffing and byte completion on the same bit event.
    assign keep_bit   = bit_ev && in_pkt && !bus.eop && !stuff_slot;
    assign stuff_err  = bit_ev && in_pkt && !bus.eop && stuff_slot && bus.d_orig;

    assign sync_ok    = (byte_val == SYNC_BYTE);
    assign overflow   = (byte_count_q == 7'(MAX_BYTES));
    assign data_byte  = byte_done && (state_q == DATA);

`ifdef RX_PID_CHECK_EN
    assign pid_bad    = (byte_count_q == 7'd0) && !pid_valid(byte_val);
`else
    assign pid_bad    = 1'b0;
`endif

    assign write_ok   = data_byte && !overflow && !pid_bad;

    rx_byte_shifter u_shifter (
        .clk       (clk),
        .n_rst     (n_rst),
        .clear     (start),
        .shift     (keep_bit),
        .bit_in    (bus.d_orig),
        .byte_val  (byte_val),
        .bit_cnt   (bit_cnt),
        .byte_done (byte_done)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= IDLE;
            rcving_q     <= 1'b0;
            w_enable_q   <= 1'b0;
            r_error_q    <= 1'b0;
            rx_data_q    <= 8'h00;
            byte_count_q <= '0;
            ones_q       <= '0;
        end else begin
            state_q      <= state_d;
            rcving_q     <= rcving_d;
            w_enable_q   <= w_enable_d;
            r_error_q    <= r_error_d;
            rx_data_q    <= rx_data_d;
            byte_count_q <= byte_count_d;
            ones_q       <= ones_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.d_edge) state_d = SYNC;
            end
            SYNC: begin
                if (bit_ev) begin
                    if (bus.eop)        state_d = ERR;
                    else if (stuff_err) state_d = ERR;
                    else if (byte_done) state_d = sync_ok ? DATA : ERR;
                end
            end
            DATA: begin
                if (bit_ev) begin
                    if (bus.eop)                                state_d = (bit_cnt == 3'd0) ? EOP_WAIT : ERR;
                    else if (stuff_err)                         state_d = ERR;
                    else if (byte_done && (overflow || pid_bad)) state_d = ERR;
                end
            end
            EOP_WAIT: begin
                if (bit_ev && !bus.eop) state_d = IDLE;
            end
            ERR: begin
                if (bit_ev && bus.eop) state_d = EOP_WAIT;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rcving_d     = (state_d != IDLE);
        w_enable_d   = write_ok;
        r_error_d    = r_error_q;
        rx_data_d    = rx_data_q;
        byte_count_d = byte_count_q;
        ones_d       = ones_q;

        if (start) begin
            r_error_d    = 1'b0;
            byte_count_d = '0;
            ones_d       = '0;
        end else begin
            if ((state_d == ERR) && (state_q != ERR)) r_error_d = 1'b1;
            if (data_byte) rx_data_d = byte_val;
            if (write_ok) byte_count_d = byte_count_q + 7'd1;
            if (bit_ev && in_pkt && !bus.eop) begin
                if (stuff_slot)       ones_d = '0;
                else if (bus.d_orig)  ones_d = ones_q + ONES_W'(1);
                else                  ones_d = '0;
            end
        end
    end

    assign bus.rcving     = rcving_q;
    assign bus.w_enable   = w_enable_q;
    assign bus.r_error    = r_error_q;
    assign bus.rx_data    = rx_data_q;
    assign bus.byte_count = byte_count_q;

endmodule

// File: tb/tb_usb_rx_sequencer.sv
// Directed vector bench for usb_rx_sequencer (built with MAX_BYTES=2 so overflow is reachable).
module tb_usb_rx_sequencer;

`ifdef RX_PID_CHECK_EN
    localparam bit PID_EN = 1'b1;
`else
    localparam bit PID_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic n_rst;
    always #5 clk = ~clk;

    usb_rx_sequencer_if bus();

    usb_rx_sequencer #(.MAX_BYTES(2), .STUFF_LIMIT(6)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    typedef struct {
        bit         rst_b;
        bit         de;
        bit         se;
        bit         d;
        bit         eop;
        bit         rcv;
        bit         we;
        bit         err;
        logic [6:0] cnt;
        bit         chk_rx;
        logic [7:0] rx;
    } vec_t;

    vec_t vq[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic add(input bit rst_b, de, se, d, eop, rcv, we, err,
                       input logic [6:0] cnt, input bit chk_rx, input logic [7:0] rx);
        vec_t v;
        v.rst_b = rst_b; v.de = de; v.se = se; v.d = d; v.eop = eop;
        v.rcv = rcv; v.we = we; v.err = err; v.cnt = cnt; v.chk_rx = chk_rx; v.rx = rx;
        vq.push_back(v);
    endtask

    // Eight bit events of one byte, LSB first; only the last one can change we/err/count.
    task automatic send_byte(input logic [7:0] b, input logic [6:0] cnt_mid,
                             input bit we_l, err_l, input logic [6:0] cnt_l);
        for (int i = 0; i < 7; i++) add(1, 0, 1, b[i], 0, 1, 0, 0, cnt_mid, 0, 8'h00);
        add(1, 0, 1, b[7], 0, 1, we_l, err_l, cnt_l, we_l, b);
    endtask

    task automatic start_pkt();
        add(1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 8'h00);
        send_byte(8'h80, 0, 0, 0, 0);
    endtask

    task automatic end_pkt(input bit err, input logic [6:0] cnt);
        add(1, 0, 1, 0, 1, 1, 0, err, cnt, 0, 8'h00);
        add(1, 0, 1, 0, 0, 0, 0, err, cnt, 0, 8'h00);
    endtask

    task automatic hw_check(input string name, input bit rcv, we, err,
                            input logic [6:0] cnt, input logic [7:0] rx);
        n_vec++;
        if (bus.rcving !== rcv || bus.w_enable !== we || bus.r_error !== err ||
            bus.byte_count !== cnt || bus.rx_data !== rx) begin
            n_bad++;
            $display("FAIL %s: got rcving=%b w_enable=%b r_error=%b byte_count=%0d rx_data=%h, want %b %b %b %0d %h",
                     name, bus.rcving, bus.w_enable, bus.r_error, bus.byte_count, bus.rx_data,
                     rcv, we, err, cnt, rx);
        end
    endtask

    initial begin
        n_rst            = 1'b0;
        bus.d_edge       = 1'b0;
        bus.shift_enable = 1'b0;
        bus.d_orig       = 1'b0;
        bus.eop          = 1'b0;

        // Reset and idle
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 8'h00);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 8'h00);
        add(1, 0, 1, 1, 0, 0, 0, 0, 0, 1, 8'h00);

        // Clean packet A5, 3C, then two eop bits
        start_pkt();
        send_byte(8'hA5, 0, 1, 0, 1);
        send_byte(8'h3C, 1, 1, 0, 2);
        add(1, 0, 1, 0, 1, 1, 0, 0, 2, 0, 8'h00);
        add(1, 0, 0, 0, 1, 1, 0, 0, 2, 0, 8'h00);
        add(1, 0, 1, 0, 1, 1, 0, 0, 2, 0, 8'h00);
        add(1, 0, 1, 0, 0, 0, 0, 0, 2, 0, 8'h00);
        add(1, 0, 0, 0, 0, 0, 0, 0, 2, 1, 8'h3C);

        // Bad SYNC 81; d_edge while in ERR is ignored; error persists into IDLE
        add(1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 8'h00);
        send_byte(8'h81, 0, 0, 1, 0);
        add(1, 0, 1, 1, 0, 1, 0, 1, 0, 0, 8'h00);
        add(1, 1, 0, 0, 0, 1, 0, 1, 0, 0, 8'h00);
        end_pkt(1, 0);
        add(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 8'h00);

        // Stuffed 0 after six 1s (SYNC's last 1 counts) is dropped; FF fails PID check when enabled
        start_pkt();
        for (int i = 0; i < 5; i++) add(1, 0, 1, 1, 0, 1, 0, 0, 0, 0, 8'h00);
        add(1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 8'h00);
        add(1, 0, 1, 1, 0, 1, 0, 0, 0, 0, 8'h00);
        add(1, 0, 1, 1, 0, 1, 0, 0, 0, 0, 8'h00);
        add(1, 0, 1, 1, 0, 1, !PID_EN, PID_EN, PID_EN ? 7'd0 : 7'd1, !PID_EN, 8'hFF);
        end_pkt(PID_EN, PID_EN ? 7'd0 : 7'd1);

        // Stuffed bit = 1 is an error
        start_pkt();
        for (int i = 0; i < 5; i++) add(1, 0, 1, 1, 0, 1, 0, 0, 0, 0, 8'h00);
        add(1, 0, 1, 1, 0, 1, 0, 1, 0, 0, 8'h00);
        end_pkt(1, 0);

        // EOP after 3 data bits
        start_pkt();
        add(1, 0, 1, 1, 0, 1, 0, 0, 0, 0, 8'h00);
        add(1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 8'h00);
        add(1, 0, 1, 1, 0, 1, 0, 0, 0, 0, 8'h00);
        add(1, 0, 1, 0, 1, 1, 0, 1, 0, 0, 8'h00);
        end_pkt(1, 0);

        // Overflow: third byte with MAX_BYTES=2
        start_pkt();
        send_byte(8'h2D, 0, 1, 0, 1);
        send_byte(8'h34, 1, 1, 0, 2);
        send_byte(8'h56, 2, 0, 1, 2);
        end_pkt(1, 2);

        // PID E1 is valid either way
        start_pkt();
        send_byte(8'hE1, 0, 1, 0, 1);
        end_pkt(0, 1);

        // PID E2 rejected only with the check enabled
        start_pkt();
        send_byte(8'hE2, 0, !PID_EN, PID_EN, PID_EN ? 7'd0 : 7'd1);
        end_pkt(PID_EN, PID_EN ? 7'd0 : 7'd1);

        // Lead-in for the mid-DATA reset sequence
        start_pkt();
        add(1, 0, 1, 1, 0, 1, 0, 0, 0, 0, 8'h00);
        add(1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 8'h00);
        add(1, 0, 1, 1, 0, 1, 0, 0, 0, 0, 8'h00);

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            n_rst            = vq[i].rst_b;
            bus.d_edge       = vq[i].de;
            bus.shift_enable = vq[i].se;
            bus.d_orig       = vq[i].d;
            bus.eop          = vq[i].eop;
            @(posedge clk);
            #1;
            n_vec++;
            if (bus.rcving !== vq[i].rcv || bus.w_enable !== vq[i].we ||
                bus.r_error !== vq[i].err || bus.byte_count !== vq[i].cnt ||
                (vq[i].chk_rx && bus.rx_data !== vq[i].rx)) begin
                n_bad++;
                $display("FAIL vec %0d: got rcving=%b w_enable=%b r_error=%b byte_count=%0d rx_data=%h, want %b %b %b %0d %h",
                         i, bus.rcving, bus.w_enable, bus.r_error, bus.byte_count, bus.rx_data,
                         vq[i].rcv, vq[i].we, vq[i].err, vq[i].cnt, vq[i].rx);
            end
        end

        // Reset asserted mid-cycle during the 4th data bit: outputs must clear without a clock edge
        @(negedge clk);
        bus.shift_enable = 1'b1;
        bus.d_orig       = 1'b1;
        #2 n_rst = 1'b0;
        #1 hw_check("async_reset", 0, 0, 0, 7'd0, 8'h00);
        @(posedge clk);
        #1 hw_check("reset_held", 0, 0, 0, 7'd0, 8'h00);
        @(negedge clk);
        n_rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.d_orig = i[0];
            @(posedge clk);
            #1 hw_check("post_reset_idle", 0, 0, 0, 7'd0, 8'h00);
            @(negedge clk);
        end
        bus.shift_enable = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
